// File: rtl/depth_engine_scheduler.sv
// depth_engine_scheduler
//   Shares N_ENGINES depth_calculator engines across the raster. Pixel coordinates
//   are issued round-robin to free engines. Each engine's final_depth is captured
//   into its slot. Results retire strictly in raster order toward the colour-LUT/packer.
//
//   Optional feature macro: SCHED_PERF_CNT_EN
//     When defined, this adds the stall_cnt[31:0] output, a saturating count of cycles
//     in which enable is high but the next engine in turn is not free.
//
//   Ports
//     sysclk      single clock, posedge
//     reset       synchronous, active-high
//     enable      1 = dispatch new pixels, 0 = drain only
//     eng_start   one-hot start pulse per engine
//     eng_x/eng_y raster coordinate broadcast (always the current raster position)
//     eng_done    per-engine done pulse
//     eng_depth   engine i depth on [i*DEPTH_W +: DEPTH_W]
//     out_*       in-order retire stream, valid/ready handshake
//     frame_done  pulse the cycle after the last pixel of a frame retires
//     busy        any slot occupied
//     stall_cnt   engine-starvation cycle count (SCHED_PERF_CNT_EN only)

// One engine slot: IDLE -> BUSY (dispatch) -> DONE (engine done) -> IDLE (retire).
module depth_engine_slot #(
  parameter int DEPTH_W = 8
) (
  input  logic               sysclk,
  input  logic               reset,
  input  logic               i_start,
  input  logic               i_done,
  input  logic               i_retire,
  input  logic [9:0]         i_x,
  input  logic [8:0]         i_y,
  input  logic [DEPTH_W-1:0] i_depth,
  output logic               o_idle,
  output logic               o_done,
  output logic [9:0]         o_x,
  output logic [8:0]         o_y,
  output logic [DEPTH_W-1:0] o_depth
);
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic               w_capture;
  logic [9:0]         r_x;
  logic [8:0]         r_y;
  logic [DEPTH_W-1:0] r_depth;

  // A done pulse only counts while the slot is waiting on its engine.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: if (i_start) w_state_nxt = S_BUSY;
      S_BUSY: if (i_done) begin
        w_state_nxt = S_DONE;
        w_capture   = 1'b1;
      end
      S_DONE: if (i_retire) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_depth <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (i_start && r_state == S_IDLE) begin
        r_x <= i_x;
        r_y <= i_y;
      end
      if (w_capture) r_depth <= i_depth;
    end
  end

  assign o_idle  = (r_state == S_IDLE);
  assign o_done  = (r_state == S_DONE);
  assign o_x     = r_x;
  assign o_y     = r_y;
  assign o_depth = r_depth;
endmodule

module depth_engine_scheduler #(
  parameter int N_ENGINES = 4,
  parameter int X_SIZE    = 640,
  parameter int Y_SIZE    = 480,
  parameter int DEPTH_W   = 8
) (
  input  logic                         sysclk,
  input  logic                         reset,
  input  logic                         enable,
  output logic [N_ENGINES-1:0]         eng_start,
  output logic [9:0]                   eng_x,
  output logic [8:0]                   eng_y,
  input  logic [N_ENGINES-1:0]         eng_done,
  input  logic [N_ENGINES*DEPTH_W-1:0] eng_depth,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DEPTH_W-1:0]           out_depth,
  output logic [9:0]                   out_x,
  output logic [8:0]                   out_y,
  output logic                         out_sof,
  output logic                         out_eol,
  output logic                         frame_done,
  output logic                         busy
`ifdef SCHED_PERF_CNT_EN
  ,
  output logic [31:0]                  stall_cnt
`endif
);
  localparam int         PW     = (N_ENGINES > 1) ? $clog2(N_ENGINES) : 1;
  localparam logic [9:0] X_LAST = 10'(X_SIZE - 1);
  localparam logic [8:0] Y_LAST = 9'(Y_SIZE - 1);

  logic [PW-1:0] r_dp, r_rp;
  logic [9:0]    r_cx;
  logic [8:0]    r_cy;
  logic          r_frame_done;

  logic [N_ENGINES-1:0]              w_idle, w_done, w_start, w_retire;
  logic [N_ENGINES-1:0][9:0]         w_sx;
  logic [N_ENGINES-1:0][8:0]         w_sy;
  logic [N_ENGINES-1:0][DEPTH_W-1:0] w_sd;
  logic                              w_dispatch, w_retire_go;

  // Dispatch looks only at registered slot state, so a slot retired this cycle
  // is not reused until the next one. Reset masks the start so engines see none.
  assign w_dispatch  = enable && !reset && w_idle[r_dp];
  assign w_retire_go = out_valid && out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < N_ENGINES; gi++) begin : g_slot
      assign w_start[gi]  = w_dispatch  && (r_dp == PW'(gi));
      assign w_retire[gi] = w_retire_go && (r_rp == PW'(gi));

      depth_engine_slot #(.DEPTH_W(DEPTH_W)) u_slot (
        .sysclk   (sysclk),
        .reset    (reset),
        .i_start  (w_start[gi]),
        .i_done   (eng_done[gi]),
        .i_retire (w_retire[gi]),
        .i_x      (r_cx),
        .i_y      (r_cy),
        .i_depth  (eng_depth[gi*DEPTH_W +: DEPTH_W]),
        .o_idle   (w_idle[gi]),
        .o_done   (w_done[gi]),
        .o_x      (w_sx[gi]),
        .o_y      (w_sy[gi]),
        .o_depth  (w_sd[gi])
      );
    end
  endgenerate

  // Pointers wrap by natural overflow (N_ENGINES is a power of two).
  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_dp         <= '0;
      r_rp         <= '0;
      r_cx         <= '0;
      r_cy         <= '0;
      r_frame_done <= 1'b0;
    end else begin
      if (w_dispatch) begin
        r_dp <= r_dp + PW'(1);
        if (r_cx == X_LAST) begin
          r_cx <= '0;
          r_cy <= (r_cy == Y_LAST) ? '0 : r_cy + 9'd1;
        end else begin
          r_cx <= r_cx + 10'd1;
        end
      end
      if (w_retire_go) r_rp <= r_rp + PW'(1);
      r_frame_done <= w_retire_go && (out_x == X_LAST) && (out_y == Y_LAST);
    end
  end

`ifdef SCHED_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  always_ff @(posedge sysclk) begin
    if (reset)
      r_stall_cnt <= '0;
    else if (enable && !w_idle[r_dp] && r_stall_cnt != 32'hFFFF_FFFF)
      r_stall_cnt <= r_stall_cnt + 32'd1;
  end
  assign stall_cnt = r_stall_cnt;
`endif

  assign eng_start  = w_start;
  assign eng_x      = r_cx;
  assign eng_y      = r_cy;
  assign out_valid  = w_done[r_rp];
  assign out_depth  = w_sd[r_rp];
  assign out_x      = w_sx[r_rp];
  assign out_y      = w_sy[r_rp];
  assign out_sof    = (out_x == 10'd0) && (out_y == 9'd0);
  assign out_eol    = (out_x == X_LAST);
  assign frame_done = r_frame_done;
  assign busy       = ~&w_idle;
endmodule

// File: tb/tb_depth_engine_scheduler.sv
// Bench for depth_engine_scheduler using a reduced 128x4 frame, so a full frame
// finishes in a few hundred cycles. Engines are modelled on the falling edge.
// An engine of latency L asserts done L cycles after its start cycle, and its
// depth is a fixed function of (x,y).
module tb_depth_engine_scheduler;
  localparam int N = 4, XS = 128, YS = 4, DW = 8;

  logic              sysclk = 1'b0;
  logic              reset = 1'b1, enable = 1'b0, out_ready = 1'b0;
  logic [N-1:0]      eng_start, eng_done;
  logic [N-1:0]      model_done = '0, inj_done = '0;
  logic [N*DW-1:0]   eng_depth = '0;
  logic [9:0]        eng_x, out_x;
  logic [8:0]        eng_y, out_y;
  logic [DW-1:0]     out_depth;
  logic              out_valid, out_sof, out_eol, frame_done, busy;
`ifdef SCHED_PERF_CNT_EN
  logic [31:0]       stall_cnt;
`endif

  int n_cmp = 0, n_bad = 0;
  int lat_fixed = 3;
  bit use_tab = 1'b0;
  int lat_tab[4] = '{10, 2, 5, 1};
  int cnt[N];
  bit act[N];
  logic [9:0] px[N];
  logic [8:0] py[N];
  logic [9:0] exp_rx, dx;
  logic [8:0] exp_ry, dy;
  int retired, disp_n;

  always #5 sysclk = ~sysclk;
  assign eng_done = model_done | inj_done;

  depth_engine_scheduler #(.N_ENGINES(N), .X_SIZE(XS), .Y_SIZE(YS), .DEPTH_W(DW)) dut (
    .sysclk(sysclk), .reset(reset), .enable(enable),
    .eng_start(eng_start), .eng_x(eng_x), .eng_y(eng_y),
    .eng_done(eng_done), .eng_depth(eng_depth),
    .out_valid(out_valid), .out_ready(out_ready), .out_depth(out_depth),
    .out_x(out_x), .out_y(out_y), .out_sof(out_sof), .out_eol(out_eol),
    .frame_done(frame_done), .busy(busy)
`ifdef SCHED_PERF_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  function automatic logic [DW-1:0] depth_of(logic [9:0] x, logic [8:0] y);
    return DW'(x * 7 + y * 13 + 5);
  endfunction

  function automatic int lat_of(logic [9:0] x, logic [8:0] y);
    if (use_tab && y == 9'd0 && x < 10'd4) return lat_tab[x[1:0]];
    return lat_fixed;
  endfunction

  // Engine models
  always @(negedge sysclk) begin
    for (int i = 0; i < N; i++) begin
      model_done[i] <= 1'b0;
      if (reset) begin
        act[i] <= 1'b0;
      end else if (eng_start[i]) begin
        px[i]  <= eng_x;
        py[i]  <= eng_y;
        act[i] <= 1'b1;
        cnt[i] <= lat_of(eng_x, eng_y);
      end else if (act[i]) begin
        if (cnt[i] == 1) begin
          model_done[i]          <= 1'b1;
          act[i]                 <= 1'b0;
          eng_depth[i*DW +: DW]  <= depth_of(px[i], py[i]);
        end
        cnt[i] <= cnt[i] - 1;
      end
    end
  end

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic adv_ret();
    if (exp_rx == 10'(XS - 1)) begin
      exp_rx = '0;
      exp_ry = (exp_ry == 9'(YS - 1)) ? '0 : exp_ry + 9'd1;
    end else exp_rx = exp_rx + 10'd1;
  endtask

  task automatic adv_disp();
    if (dx == 10'(XS - 1)) begin
      dx = '0;
      dy = (dy == 9'(YS - 1)) ? '0 : dy + 9'd1;
    end else dx = dx + 10'd1;
  endtask

  task automatic start_run(int lat, bit tab);
    lat_fixed = lat; use_tab = tab;
    reset = 1'b1; enable = 1'b0; out_ready = 1'b0; inj_done = '0;
    tick(); tick();
    exp_rx = '0; exp_ry = '0; dx = '0; dy = '0; retired = 0; disp_n = 0;
    reset = 1'b0; enable = 1'b1; out_ready = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; out_ready = 1'b1;
    tick(); tick();
    n_cmp++;
    if ({eng_start, out_valid, frame_done, busy} !== '0) begin
      n_bad++;
      $display("FAIL reset_ctrl: start=%b valid=%b fd=%b busy=%b, want all 0", eng_start, out_valid, frame_done, busy);
    end
    n_cmp++;
    if (out_x !== 10'd0 || out_y !== 9'd0 || out_depth !== '0) begin
      n_bad++;
      $display("FAIL reset_data: x=%0d y=%0d d=%0d, want 0", out_x, out_y, out_depth);
    end
  endtask

  // With 3-cycle engines slot 0 returns to IDLE in cycle 5, so there is one bubble at cycle 4.
  task automatic test_dispatch_order();
    logic [N-1:0] oh;
    logic [9:0]   ex;
    start_run(3, 1'b0);
    for (int k = 0; k < 40; k++) begin
      if (k < 6) begin
        oh = '0;
        if (k < 4) oh[k] = 1'b1;
        else if (k == 5) oh[0] = 1'b1;
        ex = (k < 4) ? 10'(k) : 10'd4;
        n_cmp++;
        if (eng_start !== oh || eng_x !== ex) begin
          n_bad++;
          $display("FAIL dispatch_seq c%0d: start=%b x=%0d, want start=%b x=%0d", k, eng_start, eng_x, oh, ex);
        end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (out_x !== exp_rx || out_y !== exp_ry || out_depth !== depth_of(exp_rx, exp_ry)) begin
          n_bad++;
          $display("FAIL order_basic: got (%0d,%0d) d=%0d, want (%0d,%0d) d=%0d", out_x, out_y, out_depth, exp_rx, exp_ry, depth_of(exp_rx, exp_ry));
        end
        adv_ret(); retired++;
      end
      tick();
    end
    n_cmp++;
    if (retired != 29) begin
      n_bad++;
      $display("FAIL throughput_basic: retired %0d in 40 cycles, want 29", retired);
    end
  endtask

  task automatic test_out_of_order();
    int first_v = -1;
    start_run(3, 1'b1);
    for (int k = 0; k < 60 && retired < 8; k++) begin
      if (out_valid && first_v < 0) first_v = k;
      if (out_valid && out_ready) begin
        n_cmp++;
        if (out_x !== exp_rx || out_y !== exp_ry || out_depth !== depth_of(exp_rx, exp_ry)) begin
          n_bad++;
          $display("FAIL order_ooo: got (%0d,%0d) d=%0d, want (%0d,%0d) d=%0d", out_x, out_y, out_depth, exp_rx, exp_ry, depth_of(exp_rx, exp_ry));
        end
        adv_ret(); retired++;
      end
      tick();
    end
    n_cmp++;
    if (first_v != 11 || retired != 8) begin
      n_bad++;
      $display("FAIL ooo_timing: first valid c%0d retired %0d, want c11 and 8", first_v, retired);
    end
  endtask

  task automatic test_backpressure();
    logic [9:0]    hx;
    logic [DW-1:0] hd;
    int            got, r0;
`ifdef SCHED_PERF_CNT_EN
    logic [31:0]   sc0;
    sc0 = '0;
`endif
    start_run(3, 1'b0);
    for (int k = 0; k < 12; k++) begin
      if (out_valid && out_ready) begin
        n_cmp++;
        if (out_x !== exp_rx || out_depth !== depth_of(exp_rx, exp_ry)) begin
          n_bad++;
          $display("FAIL order_bp_pre: got x=%0d d=%0d, want x=%0d d=%0d", out_x, out_depth, exp_rx, depth_of(exp_rx, exp_ry));
        end
        adv_ret(); retired++;
      end
      tick();
    end
    out_ready = 1'b0;
    got = 0;
    for (int k = 0; k < 20 && got == 0; k++) begin
      if (out_valid) got = 1;
      else tick();
    end
    n_cmp++;
    if (got == 0 || out_x !== exp_rx) begin
      n_bad++;
      $display("FAIL bp_head: valid=%b x=%0d, want valid=1 x=%0d", out_valid, out_x, exp_rx);
    end
    hx = out_x; hd = out_depth;
    for (int i = 0; i < 20; i++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_x !== hx || out_depth !== hd) begin
        n_bad++;
        $display("FAIL bp_hold c%0d: valid=%b x=%0d d=%0d, want 1 x=%0d d=%0d", i, out_valid, out_x, out_depth, hx, hd);
      end
      if (i >= 10) begin
        n_cmp++;
        if (eng_start !== '0) begin
          n_bad++;
          $display("FAIL bp_nostart c%0d: start=%b, want 0", i, eng_start);
        end
      end
`ifdef SCHED_PERF_CNT_EN
      if (i == 10) sc0 = stall_cnt;
      if (i == 19) begin
        n_cmp++;
        if (stall_cnt - sc0 !== 32'd9) begin
          n_bad++;
          $display("FAIL stall_cnt: delta %0d, want 9", stall_cnt - sc0);
        end
      end
`endif
      tick();
    end
    out_ready = 1'b1;
    r0 = retired;
    for (int k = 0; k < 20; k++) begin
      if (out_valid && out_ready) begin
        n_cmp++;
        if (out_x !== exp_rx || out_depth !== depth_of(exp_rx, exp_ry)) begin
          n_bad++;
          $display("FAIL order_bp_post: got x=%0d d=%0d, want x=%0d d=%0d", out_x, out_depth, exp_rx, depth_of(exp_rx, exp_ry));
        end
        adv_ret(); retired++;
      end
      tick();
    end
    n_cmp++;
    if (retired < r0 + 4) begin
      n_bad++;
      $display("FAIL bp_resume: retired %0d after release, want >= 4", retired - r0);
    end
  endtask

  task automatic test_full_frame();
    logic [N-1:0] oh;
    int  fd_cnt, post;
    bit  last_prev;
    fd_cnt = 0; post = 0; last_prev = 1'b0;
    start_run(3, 1'b0);
    for (int k = 0; k < 2000 && post < 3; k++) begin
      if (eng_start !== '0) begin
        oh = '0; oh[disp_n % N] = 1'b1;
        n_cmp++;
        if (eng_start !== oh || eng_x !== dx || eng_y !== dy) begin
          n_bad++;
          $display("FAIL frame_dispatch #%0d: start=%b (%0d,%0d), want %b (%0d,%0d)", disp_n, eng_start, eng_x, eng_y, oh, dx, dy);
        end
        adv_disp(); disp_n++;
      end
      n_cmp++;
      if (frame_done !== last_prev) begin
        n_bad++;
        $display("FAIL frame_done c%0d: got %b, want %b", k, frame_done, last_prev);
      end
      if (frame_done === 1'b1) fd_cnt++;
      if (out_valid) begin
        n_cmp++;
        if (out_x !== exp_rx || out_y !== exp_ry || out_depth !== depth_of(exp_rx, exp_ry) ||
            out_sof !== (exp_rx == 10'd0 && exp_ry == 9'd0) || out_eol !== (exp_rx == 10'(XS - 1))) begin
          n_bad++;
          $display("FAIL frame_retire: got (%0d,%0d) d=%0d sof=%b eol=%b, want (%0d,%0d) d=%0d", out_x, out_y, out_depth, out_sof, out_eol, exp_rx, exp_ry, depth_of(exp_rx, exp_ry));
        end
        last_prev = (exp_rx == 10'(XS - 1)) && (exp_ry == 9'(YS - 1));
        adv_ret(); retired++;
      end else last_prev = 1'b0;
      if (retired > XS * YS) post++;
      tick();
    end
    n_cmp++;
    if (fd_cnt != 1 || retired <= XS * YS) begin
      n_bad++;
      $display("FAIL frame_end: frame_done pulses %0d retired %0d, want 1 and > %0d", fd_cnt, retired, XS * YS);
    end
  endtask

  task automatic test_enable_drop();
    bit dropped, drained;
    dropped = 1'b0; drained = 1'b0;
    start_run(3, 1'b0);
    for (int k = 0; k < 300 && !dropped; k++) begin
      if (eng_x == 10'd100) begin
        enable = 1'b0; dropped = 1'b1; #1;
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (out_x !== exp_rx || out_depth !== depth_of(exp_rx, exp_ry)) begin
          n_bad++;
          $display("FAIL order_drop: got x=%0d d=%0d, want x=%0d d=%0d", out_x, out_depth, exp_rx, depth_of(exp_rx, exp_ry));
        end
        adv_ret(); retired++;
      end
      tick();
    end
    for (int k = 0; k < 40 && !drained; k++) begin
      n_cmp++;
      if (eng_start !== '0) begin
        n_bad++;
        $display("FAIL drop_nostart: start=%b, want 0", eng_start);
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (out_x !== exp_rx || out_depth !== depth_of(exp_rx, exp_ry)) begin
          n_bad++;
          $display("FAIL order_drain: got x=%0d d=%0d, want x=%0d d=%0d", out_x, out_depth, exp_rx, depth_of(exp_rx, exp_ry));
        end
        adv_ret(); retired++;
      end
      if (busy === 1'b0) drained = 1'b1;
      else tick();
    end
    n_cmp++;
    if (!dropped || !drained || exp_rx !== 10'd100 || eng_x !== 10'd100) begin
      n_bad++;
      $display("FAIL drain_state: dropped=%b drained=%b next_ret=%0d eng_x=%0d, want 1 1 100 100", dropped, drained, exp_rx, eng_x);
    end
    enable = 1'b1; #1;
    n_cmp++;
    if (eng_start !== 4'b0001 || eng_x !== 10'd100) begin
      n_bad++;
      $display("FAIL resume: start=%b x=%0d, want 0001 x=100", eng_start, eng_x);
    end
    for (int k = 0; k < 20; k++) begin
      if (out_valid && out_ready) begin
        n_cmp++;
        if (out_x !== exp_rx || out_depth !== depth_of(exp_rx, exp_ry)) begin
          n_bad++;
          $display("FAIL order_resume: got x=%0d d=%0d, want x=%0d d=%0d", out_x, out_depth, exp_rx, depth_of(exp_rx, exp_ry));
        end
        adv_ret(); retired++;
      end
      tick();
    end
    n_cmp++;
    if (exp_rx <= 10'd100) begin
      n_bad++;
      $display("FAIL resume_progress: next_ret=%0d, want > 100", exp_rx);
    end
  endtask

  task automatic test_reset_midflight();
    start_run(10, 1'b0);
    tick(); tick(); tick();
    enable = 1'b0; #1;
    n_cmp++;
    if (busy !== 1'b1 || eng_start !== '0) begin
      n_bad++;
      $display("FAIL mid_busy: busy=%b start=%b, want 1 0", busy, eng_start);
    end
    reset = 1'b1; enable = 1'b1;
    tick();
    n_cmp++;
    if ({busy, out_valid, eng_start, frame_done} !== '0 || out_x !== 10'd0 || out_depth !== '0) begin
      n_bad++;
      $display("FAIL mid_reset: busy=%b valid=%b start=%b fd=%b x=%0d d=%0d, want all 0", busy, out_valid, eng_start, frame_done, out_x, out_depth);
    end
    reset = 1'b0; enable = 1'b0; inj_done = '1; lat_fixed = 3;
    tick();
    inj_done = '0;
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL late_done: valid=%b busy=%b, want 0 0", out_valid, busy);
    end
    enable = 1'b1; #1;
    n_cmp++;
    if (eng_start !== 4'b0001 || eng_x !== 10'd0 || eng_y !== 9'd0) begin
      n_bad++;
      $display("FAIL post_reset_dispatch: start=%b (%0d,%0d), want 0001 (0,0)", eng_start, eng_x, eng_y);
    end
    for (int k = 0; k < 30; k++) begin
      if (out_valid && out_ready) begin
        n_cmp++;
        if (out_x !== exp_rx || out_y !== exp_ry || out_depth !== depth_of(exp_rx, exp_ry)) begin
          n_bad++;
          $display("FAIL order_post_reset: got (%0d,%0d) d=%0d, want (%0d,%0d) d=%0d", out_x, out_y, out_depth, exp_rx, exp_ry, depth_of(exp_rx, exp_ry));
        end
        adv_ret(); retired++;
      end
      tick();
    end
    n_cmp++;
    if (retired < 10) begin
      n_bad++;
      $display("FAIL post_reset_stream: retired %0d, want >= 10", retired);
    end
  endtask

  initial begin
    test_reset();
    test_dispatch_order();
    test_out_of_order();
    test_backpressure();
    test_full_frame();
    test_enable_drop();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
